// File: rtl/cpu_muldiv_if.sv
// Start/ready/valid handshake bundle between the execute-stage ALU (master)
// and the multi-cycle multiply/divide unit (slave).
interface cpu_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             valid;
   logic [WIDTH-1:0] result;
   logic             dz_error;

   modport master (
      output start, flush, op, a, b,
      input  ready, valid, result, dz_error
   );

   modport slave (
      input  start, flush, op, a, b,
      output ready, valid, result, dz_error
   );
endinterface

// File: rtl/cpu_muldiv.sv
// WIDTH-generic multi-cycle multiply / restoring divide unit for the execute stage.
// Optional divide-by-zero trap pulse enabled by defining MULDIV_DIVZERO_TRAP_EN.
module cpu_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic        clock,
   input  logic        reset,
   cpu_muldiv_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]         state, state_nxt;
   logic               ready_q, ready_nxt;
   logic               valid_q, valid_nxt;
   logic [WIDTH-1:0]   result_q;

   logic [WIDTH-1:0]   a_q, b_q, quo_q, dvs_q, rem_q;
   logic [2:0]         op_q;
   logic [CW-1:0]      cnt_q;
   logic               qneg_q, rneg_q;

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     rem_sh, trial;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;
   logic               mul_sgn, mul_hi, dz;
   logic [WIDTH-1:0]   mul_res, quo_fix, rem_fix, div_res;

   // Magnitudes are only taken for the signed divide ops (op[0] set)
   assign abs_a = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign abs_b = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Restoring step: shift in next dividend bit, keep trial if no borrow
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvs_q};

   assign mul_sgn = (op_q == 3'b001);
   assign mul_hi  = (op_q == 3'b001) || (op_q == 3'b010);
   assign a_ext   = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
   assign b_ext   = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
   assign prod    = a_ext * b_ext;
   assign mul_res = mul_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

   assign dz      = (b_q == '0);
   assign quo_fix = qneg_q ? -quo_q : quo_q;
   assign rem_fix = rneg_q ? -rem_q : rem_q;
   assign div_res = dz ? (op_q[1] ? a_q : '1) : (op_q[1] ? rem_fix : quo_fix);

`ifdef MULDIV_DIVZERO_TRAP_EN
   logic dz_q, dz_nxt;
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start) begin
            if (!bus.op[2])        state_nxt = S_MUL;
            else if (bus.b == '0)  state_nxt = S_FIX;
            else                   state_nxt = S_DIV;
         end
         S_MUL:   state_nxt = S_DONE;
         S_DIV:   if (cnt_q == CW'(1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (bus.flush) state_nxt = S_IDLE;
      ready_nxt = (state_nxt == S_IDLE);
      valid_nxt = (state_nxt == S_DONE);
`ifdef MULDIV_DIVZERO_TRAP_EN
      dz_nxt = (state == S_FIX) && (state_nxt == S_DONE) && dz;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         ready_q <= ready_nxt;
         valid_q <= valid_nxt;
`ifdef MULDIV_DIVZERO_TRAP_EN
         dz_q    <= dz_nxt;
`endif
      end
   end

   // Operand capture, divide iteration and result load
   always_ff @(posedge clock) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (state_nxt != S_IDLE) begin
               a_q    <= bus.a;
               b_q    <= bus.b;
               op_q   <= bus.op;
               quo_q  <= abs_a;
               dvs_q  <= abs_b;
               rem_q  <= '0;
               cnt_q  <= CW'(WIDTH);
               qneg_q <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               rneg_q <= bus.op[0] & bus.a[WIDTH-1];
            end
            S_MUL: if (state_nxt == S_DONE) result_q <= mul_res;
            S_DIV: if (state_nxt != S_IDLE) begin
               rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
               cnt_q <= cnt_q - CW'(1);
            end
            S_FIX: if (state_nxt == S_DONE) result_q <= div_res;
            default: ;
         endcase
      end
   end

   assign bus.ready  = ready_q;
   assign bus.valid  = valid_q;
   assign bus.result = result_q;
`ifdef MULDIV_DIVZERO_TRAP_EN
   assign bus.dz_error = dz_q;
`else
   assign bus.dz_error = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_muldiv.sv
// Scoreboard bench for cpu_muldiv: directed vectors push expectations, a
// monitor pops them on each valid pulse and checks result, dz_error and latency.
module tb_cpu_muldiv;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   passes = 0;
   logic [31:0] last_res = 32'd0;

`ifdef MULDIV_DIVZERO_TRAP_EN
   localparam logic DZ = 1'b1;
`else
   localparam logic DZ = 1'b0;
`endif

   logic [31:0] exp_res[$];
   logic        exp_dz[$];
   int          exp_cyc[$];
   string       exp_name[$];

   cpu_muldiv_if #(.WIDTH(32)) bus ();

   cpu_muldiv #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic void check(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", n, act, req, cyc);
   endfunction

   // Monitor: every valid pulse must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (!reset && bus.valid) begin
         if (exp_res.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: got valid=1 expected no completion (cycle %0d)", cyc);
         end else begin
            automatic string       n = exp_name.pop_front();
            automatic logic [31:0] r = exp_res.pop_front();
            automatic logic        d = exp_dz.pop_front();
            automatic int          c = exp_cyc.pop_front();
            check({n, "_result"}, bus.result, r);
            check({n, "_dz"}, 32'(bus.dz_error), 32'(d));
            check({n, "_cycle"}, 32'(cyc), 32'(c));
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic dz, input int lat, input string n);
      int k;
      k = 0;
      @(negedge clock);
      while (!bus.ready && k < 200) begin
         @(negedge clock);
         k++;
      end
      if (!bus.ready) begin
         checks++;
         $display("FAIL %s_ready_timeout: got ready=0 expected ready=1 within 200 cycles", n);
         return;
      end
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clock);
      #1;
      exp_res.push_back(r);
      exp_dz.push_back(dz);
      exp_cyc.push_back(cyc + lat - 1);
      exp_name.push_back(n);
      bus.start = 1'b0;
      last_res  = r;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_res.size() != 0 || !bus.ready) && k < 200) begin
         @(negedge clock);
         k++;
      end
      checks++;
      if (exp_res.size() == 0 && bus.ready) passes++;
      else $display("FAIL drain: got %0d pending ops expected 0", exp_res.size());
   endtask

   // Launch a long DIVU, poke an ignored start, then abort it at cycle 10
   task automatic abort_test(input logic use_reset, input string n);
      int k;
      k = 0;
      @(negedge clock);
      while (!bus.ready && k < 200) begin
         @(negedge clock);
         k++;
      end
      bus.start = 1'b1;
      bus.op    = 3'b100;
      bus.a     = 32'd1000;
      bus.b     = 32'd3;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clock);
      check({n, "_busy_ready"}, 32'(bus.ready), 32'd0);
      bus.start = 1'b1;
      bus.op    = 3'b000;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (6) @(negedge clock);
      if (use_reset) reset = 1'b1;
      else           bus.flush = 1'b1;
      @(posedge clock);
      #1;
      reset     = 1'b0;
      bus.flush = 1'b0;
      if (use_reset) last_res = 32'd0;
      @(negedge clock);
      check({n, "_ready"}, 32'(bus.ready), 32'd1);
      check({n, "_kept_result"}, bus.result, last_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 3'b000;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_dz", 32'(bus.dz_error), 32'd0);
      reset = 1'b0;

      issue(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 2,  "mul");
      issue(3'b001, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 2,  "mulh_neg");
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 2, "mulh_minmin");
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 2, "mulhu_max");
      issue(3'b011, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 2, "mul_rsvd");
      issue(3'b101, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 34, "divs_m7_2");
      issue(3'b111, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 34, "mods_m7_2");
      issue(3'b100, 32'd100,      32'd7,        32'd14,        1'b0, 34, "divu_100_7");
      issue(3'b110, 32'd100,      32'd7,        32'd2,         1'b0, 34, "modu_100_7");
      issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34, "divs_ovf");
      issue(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1'b0, 34, "mods_ovf");
      issue(3'b101, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, "divs_7_m2");
      issue(3'b111, 32'd7,        32'hFFFF_FFFE, 32'd1,        1'b0, 34, "mods_7_m2");
      issue(3'b100, 32'h8000_0000, 32'd1,       32'h8000_0000, 1'b0, 34, "divu_msb");
      issue(3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, DZ,   2,  "divu_dz");
      issue(3'b110, 32'd5,        32'd0,        32'd5,         DZ,   2,  "modu_dz");
      issue(3'b111, 32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFF9, DZ,   2,  "mods_dz");
      drain();

      abort_test(1'b0, "flush");
      issue(3'b000, 32'd6, 32'd9, 32'd54, 1'b0, 2, "mul_after_flush");
      drain();

      abort_test(1'b1, "reset");
      issue(3'b000, 32'd11, 32'd13, 32'd143, 1'b0, 2, "mul_after_reset");
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
